// File: rtl/b4_axil_mem_slave.sv
// b4_axil_mem_slave: AXI4-Lite slave backed by a flop-array word memory.
// Independent write (AW+W -> B) and read (AR -> R) state machines, each
// giving one transaction per two cycles; every output comes from a flop.
// Optional feature macro: B4_AXIL_RANGE_CHECK_EN. When defined, accesses at
// or above MEM_DEPTH*4 answer SLVERR (writes dropped, reads return 0).
// When undefined, such addresses alias modulo MEM_DEPTH*4 and answer OKAY.
module b4_axil_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e                w_state_q, w_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];

    r_state_e                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    wr_addr_ok;
    logic                    rd_addr_ok;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic                    unused_addr_bits;

    // Byte-offset bits (and, without range checking, the upper read-address
    // bits) carry no information for a word memory.
    assign unused_addr_bits = ^{s_araddr[ADDR_WIDTH-1:IDX_W+2], s_araddr[1:0]};

    assign wr_idx = awaddr_d[IDX_W+1:2];
    assign rd_idx = s_araddr[IDX_W+1:2];

`ifdef B4_AXIL_RANGE_CHECK_EN
    assign wr_addr_ok = (awaddr_d[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign rd_addr_ok = (s_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);
`else
    assign wr_addr_ok = 1'b1;
    assign rd_addr_ok = 1'b1;
`endif

    // Write FSM: capture AW and W independently, commit once both are held.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves a latch.
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_d     = mem_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_awaddr;
                end
                if (s_wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    // Commit on the same edge as the last handshake.
                    if (wr_addr_ok) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_d[b]) begin
                                mem_d[wr_idx][8*b +: 8] = wdata_d[8*b +: 8];
                            end
                        end
                    end
                    bresp_d   = wr_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (bvalid_q && s_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: register data on the AR handshake, hold it until R handshake.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_arvalid && arready_q) begin
                    // Reads mem_q, so a same-edge write to this word is not seen.
                    rdata_d   = rd_addr_ok ? mem_q[rd_idx] : '0;
                    rresp_d   = rd_addr_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State, handshake and memory registers; reset clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            // NOTE: the memory is reset on purpose: contents must read 0 after reset.
            mem_q     <= '{default: '0};
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            mem_q     <= mem_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_b4_axil_mem_slave.sv
// Testbench for b4_axil_mem_slave: table of single write/read transactions
// plus directed sequences for split AW/W, back-pressure, same-edge
// read/write and mid-transaction reset. Honours B4_AXIL_RANGE_CHECK_EN.
module tb_b4_axil_mem_slave;

`ifdef B4_AXIL_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    b4_axil_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64)) dut (
        .clock(clock), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write with optional AW/W start delays and B back-pressure (cycles).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold,
                             output logic [1:0] resp);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        logic [1:0] first_resp;
        resp = 2'bxx;
        @(negedge clock);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (cyc >= aw_dly && !aw_done) s_awvalid = 1'b1;
            if (cyc >= w_dly && !w_done) s_wvalid = 1'b1;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clock);
            cyc++;
            if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_wvalid = 1'b0;  end
            if (aw_done && !w_done) begin
                check("aw_held_awready", s_awready, 0);
                check("aw_held_bvalid", s_bvalid, 0);
            end
            if (w_done && !aw_done) begin
                check("w_held_wready", s_wready, 0);
                check("w_held_bvalid", s_bvalid, 0);
            end
        end
        if (!(aw_done && w_done)) begin
            check("write_hs_timeout", 0, 1);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        check("bvalid_latency", s_bvalid, 1);
        check("bresp_awready_low", s_awready, 0);
        first_resp = s_bresp;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge clock);
            check("bhold_bvalid", s_bvalid, 1);
            check("bhold_bresp", s_bresp, first_resp);
            check("bhold_awready", s_awready, 0);
            check("bhold_wready", s_wready, 0);
        end
        s_bready = 1'b1;
        @(negedge clock);
        s_bready = 1'b0;
        check("bvalid_clear", s_bvalid, 0);
        check("awready_back", s_awready, 1);
        resp = first_resp;
    endtask

    // Read with optional R back-pressure (cycles).
    task automatic axi_read(input logic [31:0] addr, input int r_hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        bit done = 0, hs;
        data = 'x; resp = 2'bxx;
        @(negedge clock);
        s_araddr = addr;
        while (!done && cyc < 50) begin
            s_arvalid = 1'b1;
            hs = s_arvalid && s_arready;
            @(negedge clock);
            cyc++;
            if (hs) begin done = 1; s_arvalid = 1'b0; end
        end
        if (!done) begin
            check("read_hs_timeout", 0, 1);
            s_arvalid = 1'b0;
            return;
        end
        check("rvalid_latency", s_rvalid, 1);
        check("rdata_arready_low", s_arready, 0);
        data = s_rdata; resp = s_rresp;
        for (int i = 0; i < r_hold; i++) begin
            @(negedge clock);
            check("rhold_rvalid", s_rvalid, 1);
            check("rhold_rdata", s_rdata, data);
            check("rhold_rresp", s_rresp, resp);
            check("rhold_arready", s_arready, 0);
        end
        s_rready = 1'b1;
        @(negedge clock);
        s_rready = 1'b0;
        check("rvalid_clear", s_rvalid, 0);
        check("arready_back", s_arready, 1);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 2'b00, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 32'h13,  32'h55667788, 4'hA, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 2'b00, 32'h55227744};
        vecs[6]  = '{1'b1, 32'hFC,  32'hA5A5A5A5, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'hFC,  32'h0,        4'h0, 2'b00, 32'hA5A5A5A5};
        vecs[8]  = '{1'b1, 32'h100, 32'hCAFEF00D, 4'hF, RC ? 2'b10 : 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h100, 32'h0,        4'h0, RC ? 2'b10 : 2'b00, RC ? 32'h0 : 32'hCAFEF00D};
        vecs[10] = '{1'b0, 32'h000, 32'h0,        4'h0, 2'b00, RC ? 32'h0 : 32'hCAFEF00D};
        vecs[11] = '{1'b0, 32'h104, 32'h0,        4'h0, RC ? 2'b10 : 2'b00, 32'h0};

        // Reset state, asynchronous and after clock edges.
        #1;
        check("rst_awready", s_awready, 0);
        check("rst_bvalid", s_bvalid, 0);
        check("rst_rvalid", s_rvalid, 0);
        repeat (2) @(negedge clock);
        check("rst_arready", s_arready, 0);
        check("rst_wready", s_wready, 0);
        check("rst_bresp", s_bresp, 0);
        check("rst_rresp", s_rresp, 0);
        check("rst_rdata", s_rdata, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_awready", s_awready, 1);
        check("post_rst_wready", s_wready, 1);
        check("post_rst_arready", s_arready, 1);

        // Table of single transactions.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, 0, rd, resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end

        // AW three cycles before W, then W three cycles before AW.
        axi_write(32'h20, 32'h01020304, 4'hF, 0, 3, 0, resp);
        check("awfirst_bresp", resp, 0);
        axi_write(32'h24, 32'h0A0B0C0D, 4'hF, 3, 0, 0, resp);
        check("wfirst_bresp", resp, 0);
        axi_read(32'h20, 0, rd, resp);
        check("awfirst_rdata", rd, 32'h01020304);
        axi_read(32'h24, 0, rd, resp);
        check("wfirst_rdata", rd, 32'h0A0B0C0D);

        // Back-pressure on B and R for five cycles.
        axi_write(32'h28, 32'h600DF00D, 4'hF, 0, 0, 5, resp);
        check("bhold_final_bresp", resp, 0);
        axi_read(32'h28, 5, rd, resp);
        check("rhold_final_rdata", rd, 32'h600DF00D);

        // Same-edge write and read of one word: read sees the old value.
        @(negedge clock);
        s_awaddr = 32'h20; s_wdata = 32'h99999999; s_wstrb = 4'hF; s_araddr = 32'h20;
        check("simul_ready", {s_awready, s_wready, s_arready}, 3'b111);
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clock);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("simul_bvalid", s_bvalid, 1);
        check("simul_rvalid", s_rvalid, 1);
        check("simul_old_rdata", s_rdata, 32'h01020304);
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clock);
        s_bready = 1'b0; s_rready = 1'b0;
        axi_read(32'h20, 0, rd, resp);
        check("simul_new_rdata", rd, 32'h99999999);

        // Reset while bvalid is high.
        @(negedge clock);
        s_awaddr = 32'h10; s_wdata = 32'h12345678; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clock);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("pre_rst_bvalid", s_bvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_bvalid", s_bvalid, 0);
        check("async_rst_awready", s_awready, 0);
        @(negedge clock);
        reset = 1'b0;

        // Reset while rvalid is high.
        @(negedge clock);
        s_araddr = 32'h24; s_arvalid = 1'b1;
        @(negedge clock);
        s_arvalid = 1'b0;
        check("pre_rst_rvalid", s_rvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rvalid", s_rvalid, 0);
        check("async_rst_rdata", s_rdata, 0);
        check("async_rst_arready", s_arready, 0);
        @(negedge clock);
        reset = 1'b0;

        axi_read(32'h10, 0, rd, resp);
        check("mem_cleared_rdata", rd, 32'h0);
        check("mem_cleared_rresp", resp, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
